pc_sequencer: RTL

//  Next-PC controller for the instruction-fetch stage; owns the program counter register.

---
 rtl/pc_sequencer_pkg.sv | 24 ++
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer_pc_reg.sv | 21 ++
 rtl/pc_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage next-PC controller: state encoding,
// default vectors and target alignment helpers.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DELAY = 2'd1,
        ST_HALT  = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

    // Word-align a redirect target by clearing its two low bits.
    function automatic logic [31:0] align_target(input logic [31:0] t);
        return {t[31:2], 2'b00};
    endfunction

    // True when a redirect target is not word aligned.
    function automatic logic misaligned(input logic [31:0] t);
        return |t[1:0];
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between decode/branch-resolve logic (master)
// and the next-PC controller (slave).
interface pc_sequencer_if;

    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        Exception;
    logic        Halt;
    logic        Resume;
    logic [31:0] PCResult;
    logic [31:0] PCPlus4;
    logic [31:0] EPC;
    logic        FetchValid;
    logic        AlignErr;
    logic [1:0]  State;

    modport master (
        output Stall, BranchTaken, BranchTarget, Jump, JumpTarget,
               Exception, Halt, Resume,
        input  PCResult, PCPlus4, EPC, FetchValid, AlignErr, State
    );

    modport slave (
        input  Stall, BranchTaken, BranchTarget, Jump, JumpTarget,
               Exception, Halt, Resume,
        output PCResult, PCPlus4, EPC, FetchValid, AlignErr, State
    );

endinterface

// File: rtl/pc_sequencer_pc_reg.sv
// 32-bit program counter register with load enable and asynchronous reset.
module pc_reg #(
    parameter logic [31:0] RESET_VALUE = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // Load the next PC when enabled; reset forces the reset vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: selects sequential / branch / jump / exception fetch
// address, handles optional branch delay slot, stall and halt/resume, and
// captures EPC on exceptions.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR,
    parameter int unsigned DELAY_SLOT   = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    pc_sequencer_if.slave bus
);

    pc_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] req_tgt;
    logic        pc_en;
    logic        ret_delay_q, ret_delay_d;
    logic        started_q;
    logic        aerr_q, aerr_d;
    logic        req, hold;

    pc_reg #(.RESET_VALUE(RESET_VECTOR)) u_pc_reg (
        .clk (Clk),
        .rst (Reset),
        .en  (pc_en),
        .d   (pc_d),
        .q   (pc_q)
    );

    assign pc_plus4 = pc_q + 32'd4;
    assign req      = bus.Jump | bus.BranchTaken;
    assign req_tgt  = bus.Jump ? bus.JumpTarget : bus.BranchTarget;
    // The first edge after reset only validates the fetch at RESET_VECTOR,
    // so the PC advances only once that fetch has actually been presented.
    assign hold     = bus.Stall | ~started_q;

    // Next-state, next-PC and target-latch selection by priority.
    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b0;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        epc_d       = epc_q;
        ret_delay_d = ret_delay_q;
        aerr_d      = 1'b0;
        if (bus.Exception) begin
            pc_en       = 1'b1;
            pc_d        = EXC_VECTOR;
            epc_d       = pc_q;
            tgt_d       = '0;
            ret_delay_d = 1'b0;
            state_d     = ST_RUN;
        end else begin
            unique case (state_q)
                ST_HALT: begin
                    if (!bus.Halt && bus.Resume) begin
                        state_d = ret_delay_q ? ST_DELAY : ST_RUN;
                    end
                end
                ST_RUN, ST_DELAY: begin
                    if (bus.Halt) begin
                        // Remember whether a redirect is still owed on resume.
                        ret_delay_d = (state_q == ST_DELAY);
                        state_d     = ST_HALT;
                    end else if (!hold) begin
                        pc_en = 1'b1;
                        if (state_q == ST_DELAY) begin
                            pc_d    = tgt_q;
                            state_d = ST_RUN;
                        end else if (req) begin
                            aerr_d = misaligned(req_tgt);
                            if (DELAY_SLOT != 0) begin
                                pc_d    = pc_plus4;
                                tgt_d   = align_target(req_tgt);
                                state_d = ST_DELAY;
                            end else begin
                                pc_d = align_target(req_tgt);
                            end
                        end else begin
                            pc_d = pc_plus4;
                        end
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Control state, pending target, EPC and alignment pulse registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_RUN;
            tgt_q       <= '0;
            epc_q       <= '0;
            ret_delay_q <= 1'b0;
            started_q   <= 1'b0;
            aerr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            epc_q       <= epc_d;
            ret_delay_q <= ret_delay_d;
            started_q   <= 1'b1;
            aerr_q      <= aerr_d;
        end
    end

    assign bus.PCResult   = pc_q;
    assign bus.PCPlus4    = pc_plus4;
    assign bus.EPC        = epc_q;
    assign bus.FetchValid = started_q && (state_q != ST_HALT);
    assign bus.AlignErr   = aerr_q;
    assign bus.State      = state_q;

endmodule
